// File: rtl/fifo_cascade_param.sv
// fifo_cascade_param: single-clock FIFO of depth D = STAGES*SEG_DEPTH.
// Storage is split across STAGES segment memories of SEG_DEPTH words.
//
// Ports:
//   clk            clock
//   rst            async active-low reset
//   push_i, di     write request and data
//   pop_i          read request
//   do_o, valid_o  read data, valid the cycle after an accepted pop
//   full_o, almost_full_o, empty_o, almost_empty_o   status flags
//   level_o        stored word count
//   ovf_o, udf_o   sticky overflow / underflow
//   clr_err_i      clears sticky flags (and high-water mark)
//   hwm_o          high-water mark, only with FIFO_CASCADE_STATS_EN
//
// Optional feature macro: FIFO_CASCADE_STATS_EN
module fifo_cascade_param #(
  parameter int WIDTH     = 20,
  parameter int SEG_DEPTH = 1024,
  parameter int STAGES    = 3,
  parameter int AF_OFFSET = 2,
  parameter int AE_OFFSET = 15,
  localparam int D        = STAGES * SEG_DEPTH,
  localparam int LW       = $clog2(D + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] di,
  input  logic             pop_i,
  output logic [WIDTH-1:0] do_o,
  output logic             valid_o,
  output logic             full_o,
  output logic             almost_full_o,
  output logic             empty_o,
  output logic             almost_empty_o,
  output logic [LW-1:0]    level_o,
  output logic             ovf_o,
  output logic             udf_o,
  input  logic             clr_err_i
`ifdef FIFO_CASCADE_STATS_EN
  ,
  output logic [LW-1:0]    hwm_o
`endif
);

  localparam int PW = $clog2(D);
  localparam int OW = $clog2(SEG_DEPTH);
  localparam int SW = (STAGES > 1) ? $clog2(STAGES) : 1;

  localparam logic [LW-1:0] AF_LVL = LW'(D - AF_OFFSET);
  localparam logic [LW-1:0] AE_LVL = LW'(AE_OFFSET);
  localparam logic [LW-1:0] FULL_L = LW'(D);
  localparam logic [PW-1:0] LAST_P = PW'(D - 1);

  logic [PW-1:0] wptr_q;
  logic [PW-1:0] rptr_q;
  logic [LW-1:0] level_q;
  logic [LW-1:0] level_n;
  logic          valid_q;
  logic          ovf_q;
  logic          udf_q;
  logic [STAGES-1:0] sel_q;

  logic push_acc;
  logic pop_acc;

  logic [SW-1:0] wseg;
  logic [SW-1:0] rseg;
  logic [OW-1:0] woff;
  logic [OW-1:0] roff;

  logic [STAGES-1:0][WIDTH-1:0] seg_out;

  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    return (p == LAST_P) ? '0 : p + 1'b1;
  endfunction

  // Flags come straight from the registered level.
  assign full_o         = (level_q == FULL_L);
  assign empty_o        = (level_q == '0);
  assign almost_full_o  = (level_q >= AF_LVL);
  assign almost_empty_o = (level_q <= AE_LVL);

  assign push_acc = push_i && !full_o;
  assign pop_acc  = pop_i && !empty_o;

  assign wseg = SW'(wptr_q >> OW);
  assign rseg = SW'(rptr_q >> OW);
  assign woff = wptr_q[OW-1:0];
  assign roff = rptr_q[OW-1:0];

  always_comb begin
    level_n = level_q;
    unique case (1'b1)
      (push_acc && !pop_acc): level_n = level_q + 1'b1;
      (pop_acc && !push_acc): level_n = level_q - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      sel_q   <= '0;
    end else begin
      if (push_acc)
        wptr_q <= ptr_inc(wptr_q);
      if (pop_acc) begin
        rptr_q <= ptr_inc(rptr_q);
        sel_q  <= STAGES'(1) << rseg;
      end
      level_q <= level_n;
      valid_q <= pop_acc;
      // A new error event beats a clear in the same cycle.
      if (push_i && full_o)
        ovf_q <= 1'b1;
      else if (clr_err_i)
        ovf_q <= 1'b0;
      if (pop_i && empty_o)
        udf_q <= 1'b1;
      else if (clr_err_i)
        udf_q <= 1'b0;
    end
  end

  // One memory per segment; only the addressed one is touched.
  // Each segment keeps its own read register so that do_o only
  // depends on the registered one-hot select.
  for (genvar g = 0; g < STAGES; g++) begin : g_seg
    logic [WIDTH-1:0] mem [SEG_DEPTH];
    logic [WIDTH-1:0] rd_q;

    always_ff @(posedge clk) begin
      if (push_acc && (wseg == SW'(g)))
        mem[woff] <= di;
      if (pop_acc && (rseg == SW'(g)))
        rd_q <= mem[roff];
    end

    assign seg_out[g] = sel_q[g] ? rd_q : '0;
  end

  // sel_q is zero after reset, which forces do_o to zero.
  always_comb begin
    do_o = '0;
    for (int s = 0; s < STAGES; s++)
      do_o = do_o | seg_out[s];
  end

  assign valid_o = valid_q;
  assign level_o = level_q;
  assign ovf_o   = ovf_q;
  assign udf_o   = udf_q;

`ifdef FIFO_CASCADE_STATS_EN
  logic [LW-1:0] hwm_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      hwm_q <= '0;
    else if (clr_err_i)
      hwm_q <= level_n;
    else if (level_n > hwm_q)
      hwm_q <= level_n;
  end

  assign hwm_o = hwm_q;
`endif

endmodule

// File: tb/tb_fifo_cascade_param.sv
// tb_fifo_cascade_param: directed + random bench for
// fifo_cascade_param with WIDTH=20, SEG_DEPTH=16, STAGES=3.
module tb_fifo_cascade_param;

  localparam int WIDTH     = 20;
  localparam int SEG_DEPTH = 16;
  localparam int STAGES    = 3;
  localparam int D         = 48;
  localparam int LW        = 6;
  localparam int AF_OFS    = 2;
  localparam int AE_OFS    = 15;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             push_i = 1'b0;
  logic             pop_i = 1'b0;
  logic             clr_err_i = 1'b0;
  logic [WIDTH-1:0] di = '0;
  logic [WIDTH-1:0] do_o;
  logic             valid_o;
  logic             full_o;
  logic             almost_full_o;
  logic             empty_o;
  logic             almost_empty_o;
  logic [LW-1:0]    level_o;
  logic             ovf_o;
  logic             udf_o;
`ifdef FIFO_CASCADE_STATS_EN
  logic [LW-1:0]    hwm_o;
`endif

  int checks = 0;
  int failures = 0;

  logic [WIDTH-1:0] ref_q [$];
  int               m_lvl = 0;
  int               m_hwm = 0;
  logic [WIDTH-1:0] m_do = '0;
  logic             m_ovf = 1'b0;
  logic             m_udf = 1'b0;

  always #5 clk = ~clk;

  fifo_cascade_param #(
    .WIDTH     (WIDTH),
    .SEG_DEPTH (SEG_DEPTH),
    .STAGES    (STAGES),
    .AF_OFFSET (AF_OFS),
    .AE_OFFSET (AE_OFS)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .push_i         (push_i),
    .di             (di),
    .pop_i          (pop_i),
    .do_o           (do_o),
    .valid_o        (valid_o),
    .full_o         (full_o),
    .almost_full_o  (almost_full_o),
    .empty_o        (empty_o),
    .almost_empty_o (almost_empty_o),
    .level_o        (level_o),
    .ovf_o          (ovf_o),
    .udf_o          (udf_o),
    .clr_err_i      (clr_err_i)
`ifdef FIFO_CASCADE_STATS_EN
    ,
    .hwm_o          (hwm_o)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string ph);
    chk({ph, "_level"}, 32'(level_o), 32'(m_lvl));
    chk({ph, "_full"}, 32'(full_o), 32'(m_lvl == D));
    chk({ph, "_afull"}, 32'(almost_full_o),
        32'(m_lvl >= D - AF_OFS));
    chk({ph, "_empty"}, 32'(empty_o), 32'(m_lvl == 0));
    chk({ph, "_aempty"}, 32'(almost_empty_o),
        32'(m_lvl <= AE_OFS));
    chk({ph, "_ovf"}, 32'(ovf_o), 32'(m_ovf));
    chk({ph, "_udf"}, 32'(udf_o), 32'(m_udf));
    chk({ph, "_do"}, 32'(do_o), 32'(m_do));
`ifdef FIFO_CASCADE_STATS_EN
    chk({ph, "_hwm"}, 32'(hwm_o), 32'(m_hwm));
`endif
  endtask

  // One clock: drive, predict with the model, sample at edge+1.
  task automatic cyc(input logic p, input logic q,
                     input logic [WIDTH-1:0] d,
                     input logic c, input string ph);
    logic ap;
    logic aq;
    push_i = p;
    pop_i = q;
    di = d;
    clr_err_i = c;
    ap = p && (m_lvl != D);
    aq = q && (m_lvl != 0);
    if (p && m_lvl == D) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
    if (q && m_lvl == 0) m_udf = 1'b1;
    else if (c) m_udf = 1'b0;
    if (aq) m_do = ref_q.pop_front();
    if (ap) ref_q.push_back(d);
    m_lvl = m_lvl + int'(ap) - int'(aq);
    if (c) m_hwm = m_lvl;
    else if (m_lvl > m_hwm) m_hwm = m_lvl;
    @(posedge clk);
    #1;
    push_i = 1'b0;
    pop_i = 1'b0;
    clr_err_i = 1'b0;
    chk({ph, "_valid"}, 32'(valid_o), 32'(aq));
    chk_state(ph);
  endtask

  initial begin
    logic p;
    logic q;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk_state("rst");
    rst = 1'b1;
    cyc(1'b0, 1'b0, '0, 1'b0, "idle");

    for (int i = 1; i <= D; i++)
      cyc(1'b1, 1'b0, WIDTH'(i), 1'b0, "fill");

    for (int i = 1; i <= D; i++)
      cyc(1'b0, 1'b1, '0, 1'b0, "drain");

    for (int i = 0; i < D; i++)
      cyc(1'b1, 1'b0, WIDTH'(32'h100 + i), 1'b0, "fill2");
    cyc(1'b1, 1'b1, 20'hFFFFF, 1'b0, "pp_full");
    cyc(1'b0, 1'b0, '0, 1'b1, "clr_ovf");

    while (m_lvl > 0)
      cyc(1'b0, 1'b1, '0, 1'b0, "drain2");
    cyc(1'b1, 1'b1, 20'h5A5A5, 1'b0, "pp_empty");
    cyc(1'b0, 1'b0, '0, 1'b1, "clr_udf");

    for (int i = 0; i < 23; i++)
      cyc(1'b1, 1'b0, WIDTH'($urandom), 1'b0, "pre_rand");
    for (int i = 0; i < 200; i++) begin
      p = ($urandom_range(0, 99) < 55);
      q = ($urandom_range(0, 99) < 50);
      cyc(p, q, WIDTH'($urandom), 1'b0, "rand");
    end

    while (m_lvl > 0)
      cyc(1'b0, 1'b1, '0, 1'b0, "drain3");
    cyc(1'b0, 1'b0, '0, 1'b1, "clr_all");
    for (int i = 0; i < 30; i++)
      cyc(1'b1, 1'b0, WIDTH'(32'h700 + i), 1'b0, "fill30");

    // Asynchronous reset in the middle of a cycle.
    #2;
    rst = 1'b0;
    #1;
    ref_q.delete();
    m_lvl = 0;
    m_hwm = 0;
    m_do = '0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
    chk("arst_valid", 32'(valid_o), 32'd0);
    chk_state("arst");
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc(1'b1, 1'b0, 20'hABCDE, 1'b0, "post_push");
    cyc(1'b0, 1'b1, '0, 1'b0, "post_pop");
    cyc(1'b0, 1'b0, '0, 1'b0, "post_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
